// File: rtl/load_store_unit.sv
// load_store_unit
//
// Execute-stage load/store address unit for the RV32I pipeline. Computes the
// effective address rs1 + imm for memory ops and decodes access size,
// signedness, byte lanes and alignment. The decode is presented
// combinationally and also captured into a registered EX/MEM bundle.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset; clears every *_q output
//   rs1, imm       base register value and sign-extended immediate
//   aluSelect      6-bit operation code from decode
//   enable         1: *_q outputs load; 0: *_q outputs hold (stall)
//   address        combinational effective address (0 for non-memory ops)
//   is_load        combinational load decode
//   is_store       combinational store decode
//   byte_en        combinational byte-lane enables
//   misaligned     combinational alignment fault
//   mem_address_q  registered address
//   mem_read_q     registered read strobe (suppressed on a fault)
//   mem_write_q    registered write strobe (suppressed on a fault)
//   mem_byte_en_q  registered byte-lane enables
//   mem_size_q     registered size: 00 byte, 01 half, 10 word
//   mem_unsigned_q registered zero-extend flag (LBU/LHU only)
//   misaligned_q   registered alignment fault
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rs1,
  input  logic [31:0] imm,
  input  logic [5:0]  aluSelect,
  input  logic        enable,
  output logic [31:0] address,
  output logic        is_load,
  output logic        is_store,
  output logic [3:0]  byte_en,
  output logic        misaligned,
  output logic [31:0] mem_address_q,
  output logic        mem_read_q,
  output logic        mem_write_q,
  output logic [3:0]  mem_byte_en_q,
  output logic [1:0]  mem_size_q,
  output logic        mem_unsigned_q,
  output logic        misaligned_q
);

  localparam logic [5:0] OpLb  = 6'b001011;
  localparam logic [5:0] OpLh  = 6'b001100;
  localparam logic [5:0] OpLw  = 6'b001101;
  localparam logic [5:0] OpLbu = 6'b001110;
  localparam logic [5:0] OpLhu = 6'b001111;
  localparam logic [5:0] OpSb  = 6'b010000;
  localparam logic [5:0] OpSh  = 6'b010001;
  localparam logic [5:0] OpSw  = 6'b010010;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  logic        mem_op;
  logic [1:0]  size;
  logic        ld_unsigned;
  logic [31:0] eff_addr;
  logic [1:0]  addr_lo;

  // Opcode decode
  always_comb begin
    mem_op      = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
    size        = SizeByte;
    ld_unsigned = 1'b0;
    case (aluSelect)
      OpLb:  begin mem_op = 1'b1; is_load  = 1'b1; size = SizeByte; end
      OpLh:  begin mem_op = 1'b1; is_load  = 1'b1; size = SizeHalf; end
      OpLw:  begin mem_op = 1'b1; is_load  = 1'b1; size = SizeWord; end
      OpLbu: begin mem_op = 1'b1; is_load  = 1'b1; size = SizeByte; ld_unsigned = 1'b1; end
      OpLhu: begin mem_op = 1'b1; is_load  = 1'b1; size = SizeHalf; ld_unsigned = 1'b1; end
      OpSb:  begin mem_op = 1'b1; is_store = 1'b1; size = SizeByte; end
      OpSh:  begin mem_op = 1'b1; is_store = 1'b1; size = SizeHalf; end
      OpSw:  begin mem_op = 1'b1; is_store = 1'b1; size = SizeWord; end
      default: ;
    endcase
  end

  // Effective address; carry out is deliberately dropped so addresses wrap.
  assign eff_addr = rs1 + imm;
  assign address  = mem_op ? eff_addr : 32'h0;
  assign addr_lo  = address[1:0];

  // Byte lanes and alignment
  always_comb begin
    byte_en    = 4'b0000;
    misaligned = 1'b0;
    if (mem_op) begin
      case (size)
        SizeByte: byte_en = 4'b0001 << addr_lo;
        SizeHalf: begin
          byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
          misaligned = addr_lo[0];
        end
        default: begin
          byte_en    = 4'b1111;
          misaligned = (addr_lo != 2'b00);
        end
      endcase
    end
  end

  // EX/MEM bundle. Strobes are gated by the fault so a misaligned access
  // never reaches memory; the fault itself travels on in misaligned_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_address_q  <= 32'h0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_byte_en_q  <= 4'b0000;
      mem_size_q     <= 2'b00;
      mem_unsigned_q <= 1'b0;
      misaligned_q   <= 1'b0;
    end else if (enable) begin
      mem_address_q  <= address;
      mem_read_q     <= is_load & ~misaligned;
      mem_write_q    <= is_store & ~misaligned;
      mem_byte_en_q  <= byte_en;
      mem_size_q     <= size;
      mem_unsigned_q <= ld_unsigned;
      misaligned_q   <= misaligned;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rs1 = 32'h0;
  logic [31:0] imm = 32'h0;
  logic [5:0]  aluSelect = 6'h0;
  logic        enable = 1'b0;
  logic [31:0] address;
  logic        is_load, is_store, misaligned;
  logic [3:0]  byte_en;
  logic [31:0] mem_address_q;
  logic        mem_read_q, mem_write_q, mem_unsigned_q, misaligned_q;
  logic [3:0]  mem_byte_en_q;
  logic [1:0]  mem_size_q;

  load_store_unit dut (
    .clk            (clk),
    .reset          (reset),
    .rs1            (rs1),
    .imm            (imm),
    .aluSelect      (aluSelect),
    .enable         (enable),
    .address        (address),
    .is_load        (is_load),
    .is_store       (is_store),
    .byte_en        (byte_en),
    .misaligned     (misaligned),
    .mem_address_q  (mem_address_q),
    .mem_read_q     (mem_read_q),
    .mem_write_q    (mem_write_q),
    .mem_byte_en_q  (mem_byte_en_q),
    .mem_size_q     (mem_size_q),
    .mem_unsigned_q (mem_unsigned_q),
    .misaligned_q   (misaligned_q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        ld;
    logic        st;
    logic [3:0]  be;
    logic        mis;
  } comb_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [1:0]  sz;
    logic        uns;
    logic        mis;
  } bundle_t;

  int      vectors = 0;
  int      miscompares = 0;
  bundle_t exp_q[$];
  bundle_t model_state = '0;
  bit      driver_done = 1'b0;

  // Reference model: straight from the opcode table and lane/alignment rules.
  function automatic void ref_model(input logic [5:0] op, input logic [31:0] r,
                                    input logic [31:0] i, output comb_t c,
                                    output bundle_t b);
    int    nbytes;   // 0 = not a memory op
    bit    ld, uns;
    int    a;
    logic [31:0] sum;
    nbytes = 0; ld = 0; uns = 0;
    case (op)
      6'd11: begin nbytes = 1; ld = 1; end
      6'd12: begin nbytes = 2; ld = 1; end
      6'd13: begin nbytes = 4; ld = 1; end
      6'd14: begin nbytes = 1; ld = 1; uns = 1; end
      6'd15: begin nbytes = 2; ld = 1; uns = 1; end
      6'd16: nbytes = 1;
      6'd17: nbytes = 2;
      6'd18: nbytes = 4;
      default: nbytes = 0;
    endcase
    c = '0;
    b = '0;
    if (nbytes != 0) begin
      sum    = r + i;
      a      = int'(sum % 4);
      c.addr = sum;
      c.ld   = ld;
      c.st   = !ld;
      if (nbytes == 1) c.be = 4'(1 << a);
      else if (nbytes == 2) c.be = (a >= 2) ? 4'hC : 4'h3;
      else c.be = 4'hF;
      c.mis  = (nbytes == 2 && (a % 2) == 1) || (nbytes == 4 && a != 0);
      b.addr = c.addr;
      b.rd   = c.ld && !c.mis;
      b.wr   = c.st && !c.mis;
      b.be   = c.be;
      b.sz   = (nbytes == 1) ? 2'd0 : (nbytes == 2) ? 2'd1 : 2'd2;
      b.uns  = uns;
      b.mis  = c.mis;
    end
  endfunction

  task automatic step(input logic rst, input logic en, input logic [5:0] op,
                      input logic [31:0] r, input logic [31:0] i);
    comb_t   ec;
    comb_t   ac;
    bundle_t eb;
    @(negedge clk);
    reset = rst; enable = en; aluSelect = op; rs1 = r; imm = i;
    #1;
    ref_model(op, r, i, ec, eb);
    ac = '{addr: address, ld: is_load, st: is_store, be: byte_en, mis: misaligned};
    vectors++;
    if (ac !== ec) begin
      miscompares++;
      $display("FAIL comb op=%b rs1=%h imm=%h: got addr=%h ld=%b st=%b be=%b mis=%b, want addr=%h ld=%b st=%b be=%b mis=%b",
               op, r, i, ac.addr, ac.ld, ac.st, ac.be, ac.mis,
               ec.addr, ec.ld, ec.st, ec.be, ec.mis);
    end
    if (rst) model_state = '0;
    else if (en) model_state = eb;
    exp_q.push_back(model_state);
  endtask

  // Monitor: every edge presents a new registered bundle.
  initial begin
    bundle_t eb, ab;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        eb = exp_q.pop_front();
        ab = '{addr: mem_address_q, rd: mem_read_q, wr: mem_write_q, be: mem_byte_en_q,
               sz: mem_size_q, uns: mem_unsigned_q, mis: misaligned_q};
        vectors++;
        if (ab !== eb) begin
          miscompares++;
          $display("FAIL regq: got addr=%h rd=%b wr=%b be=%b sz=%b uns=%b mis=%b, want addr=%h rd=%b wr=%b be=%b sz=%b uns=%b mis=%b",
                   ab.addr, ab.rd, ab.wr, ab.be, ab.sz, ab.uns, ab.mis,
                   eb.addr, eb.rd, eb.wr, eb.be, eb.sz, eb.uns, eb.mis);
        end
      end
    end
  end

  initial begin
    logic [5:0]  op;
    logic [31:0] r, i;
    // Reset state
    step(1'b1, 1'b0, 6'd0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 6'd0, 32'h0, 32'h0);
    // Every load/store code at 0x1010
    for (int k = 11; k <= 18; k++) step(1'b0, 1'b1, 6'(k), 32'h1000, 32'h10);
    // Non-memory ops
    step(1'b0, 1'b1, 6'b011000, 32'h1000, 32'h10);
    step(1'b0, 1'b1, 6'b000111, 32'h1000, 32'h10);
    // Wrap-around LB
    step(1'b0, 1'b1, 6'b001011, 32'hFFFF_FFFF, 32'h2);
    // Misaligned SH at 0x1003
    step(1'b0, 1'b1, 6'b010001, 32'h1000, 32'h3);
    // LHU at 0x1002 then stall with new operands
    step(1'b0, 1'b1, 6'b001111, 32'h1000, 32'h2);
    step(1'b0, 1'b0, 6'b010010, 32'h2000, 32'h4);
    step(1'b0, 1'b0, 6'b001101, 32'h3001, 32'h0);
    // Reset overrides a valid SW
    step(1'b0, 1'b1, 6'b010010, 32'h4000, 32'h8);
    step(1'b1, 1'b1, 6'b010010, 32'h4000, 32'h8);
    // Misaligned words and halves at every offset
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 6'b001101, 32'h100, 32'(k));
      step(1'b0, 1'b1, 6'b001100, 32'h100, 32'(k));
      step(1'b0, 1'b1, 6'b010000, 32'h100, 32'(k));
    end
    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 8) op = 6'($urandom_range(11, 18));
      else op = 6'($urandom_range(0, 63));
      r = $urandom();
      i = $urandom();
      step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, op, r, i);
    end
    @(negedge clk);
    @(negedge clk);
    driver_done = 1'b1;
  end

  initial begin
    wait (driver_done);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected bundles left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, want completion");
    $fatal(1);
  end

endmodule
